// File: rtl/branch_sched_if.sv
// Handshake bundle between the ID-stage branch sequencer and its neighbours
// (decode, hazard unit, comparator, IF and the PC/regfile write ports).
interface branch_sched_if #(
    parameter int unsigned CNT_W = 16
);
    // decoded branch from ID
    logic             idValid;
    logic [2:0]       idBraOp;
    logic             idLink;
    logic [31:0]      idPc;
    logic [31:0]      idOffset;
    // pipeline status
    logic             opsReady;
    logic             flush;
    logic             dsAck;
    logic             takeBranch;
    // sequencer outputs
    logic             braEnable;
    logic [2:0]       braOp;
    logic             stall;
    logic             redirect;
    logic [31:0]      redirectPc;
    logic             linkWe;
    logic [31:0]      linkData;
    logic             busy;
    logic [CNT_W-1:0] brCount;
    logic [CNT_W-1:0] takenCount;

    modport master (
        output idValid, idBraOp, idLink, idPc, idOffset,
        output opsReady, flush, dsAck, takeBranch,
        input  braEnable, braOp, stall, redirect, redirectPc,
        input  linkWe, linkData, busy, brCount, takenCount
    );

    modport slave (
        input  idValid, idBraOp, idLink, idPc, idOffset,
        input  opsReady, flush, dsAck, takeBranch,
        output braEnable, braOp, stall, redirect, redirectPc,
        output linkWe, linkData, busy, brCount, takenCount
    );
endinterface

// File: rtl/branch_sched.sv
// Conditional-branch sequencer: capture, wait for operands, one-cycle compare,
// link write, delay slot, then a one-cycle PC redirect. Also counts branches.
module branch_sched #(
    parameter int unsigned CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    branch_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_EVAL  = 2'd2,
        S_DSLOT = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;

    // captured branch
    logic [2:0]         op_q;
    logic               link_q;
    logic [31:0]        pc_q;
    logic [31:0]        off_q;

    // registered outputs
    logic               en_q;
    logic               redirect_q;
    logic [31:0]        target_q;
    logic               link_we_q;
    logic [31:0]        link_data_q;
    logic               busy_q;
    logic [CNT_W-1:0]   br_cnt_q;
    logic [CNT_W-1:0]   tk_cnt_q;

    // next values for registered outputs
    logic               en_d;
    logic               redirect_d;
    logic               link_we_d;
    logic               busy_d;
    logic               br_inc_d;
    logic               tk_inc_d;

    // shared decode terms
    logic               accept_c;
    logic               capture_c;
    logic               op_valid_c;
    logic               taken_c;

    // An ID branch is accepted only when idle and not in a wrong-path redirect cycle
    assign accept_c   = (state_q == S_IDLE) && bus.idValid && !redirect_q;
    assign capture_c  = accept_c && !bus.flush;
    // ops 110/111 are not real comparator ops
    assign op_valid_c = !(op_q[2] && op_q[1]);
    assign taken_c    = op_valid_c && bus.takeBranch;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (capture_c)     state_d = S_WAIT;
            S_WAIT:  if (bus.opsReady)  state_d = S_EVAL;
            S_EVAL:  state_d = taken_c ? S_DSLOT : S_IDLE;
            S_DSLOT: if (bus.dsAck)     state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d = S_IDLE;
        end
    end

    // Output decode: next values of the registered strobes and counter enables
    always_comb begin
        en_d       = 1'b0;
        redirect_d = 1'b0;
        link_we_d  = 1'b0;
        br_inc_d   = 1'b0;
        tk_inc_d   = 1'b0;
        busy_d     = (state_d != S_IDLE);
        // comparator enable lines up with the cycle spent in EVAL
        if (state_d == S_EVAL) begin
            en_d = op_valid_c;
        end
        if ((state_q == S_EVAL) && !bus.flush) begin
            br_inc_d  = 1'b1;
            tk_inc_d  = taken_c;
            link_we_d = link_q;
        end
        if ((state_q == S_DSLOT) && bus.dsAck && !bus.flush) begin
            redirect_d = 1'b1;
        end
    end

    // Branch capture in the accept cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 3'd0;
            link_q <= 1'b0;
            pc_q   <= 32'd0;
            off_q  <= 32'd0;
        end else if (capture_c) begin
            op_q   <= bus.idBraOp;
            link_q <= bus.idLink;
            pc_q   <= bus.idPc;
            off_q  <= bus.idOffset;
        end
    end

    // Registered strobes, target/link datapath and performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q        <= 1'b0;
            redirect_q  <= 1'b0;
            target_q    <= 32'd0;
            link_we_q   <= 1'b0;
            link_data_q <= 32'd0;
            busy_q      <= 1'b0;
            br_cnt_q    <= '0;
            tk_cnt_q    <= '0;
        end else begin
            en_q       <= en_d;
            redirect_q <= redirect_d;
            link_we_q  <= link_we_d;
            busy_q     <= busy_d;
            if (state_q == S_EVAL) begin
                target_q    <= pc_q + 32'd4 + (off_q << 2);
                link_data_q <= pc_q + 32'd8;
            end
            if (br_inc_d) begin
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            end
            if (tk_inc_d) begin
                tk_cnt_q <= tk_cnt_q + CNT_W'(1);
            end
        end
    end

    // Stall is combinational so ID is frozen in the capture cycle itself
    assign bus.stall      = !bus.flush &&
                            (accept_c || (state_q == S_WAIT) || (state_q == S_EVAL));
    assign bus.braEnable  = en_q;
    assign bus.braOp      = op_q;
    assign bus.redirect   = redirect_q;
    assign bus.redirectPc = target_q;
    assign bus.linkWe     = link_we_q;
    assign bus.linkData   = link_data_q;
    assign bus.busy       = busy_q;
    assign bus.brCount    = br_cnt_q;
    assign bus.takenCount = tk_cnt_q;

endmodule

// File: tb/tb_branch_sched.sv
// Directed bench for branch_sched: walks each branch scenario step by step
// against hand-computed expected values.
module tb_branch_sched;

    localparam int unsigned CNT_W = 4;

    logic clk;
    logic rst_n;

    branch_sched_if #(.CNT_W(CNT_W)) bus ();

    branch_sched #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // running event counts sampled at each rising edge
    int n_stall = 0;
    int n_en    = 0;
    int n_red   = 0;
    int n_lwe   = 0;

    always @(posedge clk) begin
        if (bus.stall)     n_stall <= n_stall + 1;
        if (bus.braEnable) n_en    <= n_en + 1;
        if (bus.redirect)  n_red   <= n_red + 1;
        if (bus.linkWe)    n_lwe   <= n_lwe + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a branch, hold opsReady low for 'waits' WAIT cycles, then drive
    // takeBranch in EVAL. Returns 1 time unit after the edge that leaves EVAL.
    task automatic do_branch(input logic [2:0] op, input logic link,
                             input logic [31:0] pc, input logic [31:0] off,
                             input int waits, input logic take);
        bus.idValid  = 1'b1;
        bus.idBraOp  = op;
        bus.idLink   = link;
        bus.idPc     = pc;
        bus.idOffset = off;
        tick();
        bus.idValid  = 1'b0;
        bus.opsReady = 1'b0;
        repeat (waits) tick();
        bus.opsReady = 1'b1;
        tick();
        bus.opsReady   = 1'b0;
        bus.takeBranch = take;
        tick();
        bus.takeBranch = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_braEnable"},  32'(bus.braEnable),  32'd0);
        check({tag, "_braOp"},      32'(bus.braOp),      32'd0);
        check({tag, "_stall"},      32'(bus.stall),      32'd0);
        check({tag, "_redirect"},   32'(bus.redirect),   32'd0);
        check({tag, "_redirectPc"}, bus.redirectPc,      32'd0);
        check({tag, "_linkWe"},     32'(bus.linkWe),     32'd0);
        check({tag, "_linkData"},   bus.linkData,        32'd0);
        check({tag, "_busy"},       32'(bus.busy),       32'd0);
        check({tag, "_brCount"},    32'(bus.brCount),    32'd0);
        check({tag, "_takenCount"}, 32'(bus.takenCount), 32'd0);
    endtask

    int s0;
    int e0;
    int r0;
    int l0;

    initial begin
        rst_n          = 1'b0;
        bus.idValid    = 1'b0;
        bus.idBraOp    = 3'd0;
        bus.idLink     = 1'b0;
        bus.idPc       = 32'd0;
        bus.idOffset   = 32'd0;
        bus.opsReady   = 1'b0;
        bus.flush      = 1'b0;
        bus.dsAck      = 1'b0;
        bus.takeBranch = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // beq taken, step by step
        bus.idValid  = 1'b1;
        bus.idBraOp  = 3'b000;
        bus.idLink   = 1'b0;
        bus.idPc     = 32'h0040_0010;
        bus.idOffset = 32'h0000_0003;
        #1;
        check("beq_capture_stall", 32'(bus.stall), 32'd1);
        tick();                                     // cycle 1: WAIT
        bus.idValid  = 1'b0;
        bus.opsReady = 1'b1;
        check("beq_wait_busy", 32'(bus.busy), 32'd1);
        check("beq_wait_stall", 32'(bus.stall), 32'd1);
        tick();                                     // cycle 2: EVAL
        bus.opsReady = 1'b0;
        check("beq_eval_en", 32'(bus.braEnable), 32'd1);
        check("beq_eval_op", 32'(bus.braOp), 32'd0);
        bus.takeBranch = 1'b1;
        tick();                                     // cycle 3: DSLOT
        bus.takeBranch = 1'b0;
        check("beq_ds_stall", 32'(bus.stall), 32'd0);
        check("beq_ds_en", 32'(bus.braEnable), 32'd0);
        check("beq_ds_redirect", 32'(bus.redirect), 32'd0);
        check("beq_target", bus.redirectPc, 32'h0040_0020);
        check("beq_brCount", 32'(bus.brCount), 32'd1);
        check("beq_takenCount", 32'(bus.takenCount), 32'd1);
        bus.dsAck = 1'b1;
        tick();                                     // cycle 4: redirect
        bus.dsAck = 1'b0;
        check("beq_redirect", 32'(bus.redirect), 32'd1);
        check("beq_redirect_pc", bus.redirectPc, 32'h0040_0020);
        bus.idValid = 1'b1;                         // wrong-path, must be ignored
        #1;
        check("wrongpath_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.idValid = 1'b0;
        check("beq_redirect_end", 32'(bus.redirect), 32'd0);
        check("wrongpath_busy", 32'(bus.busy), 32'd0);

        // bne not taken
        s0 = n_stall; r0 = n_red;
        do_branch(3'b001, 1'b0, 32'h0000_1000, 32'd5, 0, 1'b0);
        check("bne_busy", 32'(bus.busy), 32'd0);
        tick();
        check("bne_stall_cycles", 32'(n_stall - s0), 32'd3);
        check("bne_no_redirect", 32'(n_red - r0), 32'd0);
        check("bne_brCount", 32'(bus.brCount), 32'd2);
        check("bne_takenCount", 32'(bus.takenCount), 32'd1);

        // delayed operands: three extra WAIT cycles
        s0 = n_stall; e0 = n_en;
        do_branch(3'b010, 1'b0, 32'h0000_2000, 32'd0, 3, 1'b0);
        tick();
        check("delay_stall_cycles", 32'(n_stall - s0), 32'd6);
        check("delay_en_once", 32'(n_en - e0), 32'd1);
        check("delay_brCount", 32'(bus.brCount), 32'd3);

        // bgezal not taken: link written anyway
        l0 = n_lwe; r0 = n_red;
        do_branch(3'b010, 1'b1, 32'h0000_0100, 32'd4, 0, 1'b0);
        check("bgezal_linkWe", 32'(bus.linkWe), 32'd1);
        check("bgezal_linkData", bus.linkData, 32'h0000_0108);
        check("bgezal_target", bus.redirectPc, 32'h0000_0114);
        tick();
        check("bgezal_linkWe_end", 32'(bus.linkWe), 32'd0);
        check("bgezal_link_once", 32'(n_lwe - l0), 32'd1);
        check("bgezal_no_redirect", 32'(n_red - r0), 32'd0);
        check("bgezal_brCount", 32'(bus.brCount), 32'd4);
        check("bgezal_takenCount", 32'(bus.takenCount), 32'd1);

        // target wrap upward: bgtz taken from 0xFFFFFFF8
        do_branch(3'b011, 1'b0, 32'hFFFF_FFF8, 32'h0000_0001, 0, 1'b1);
        check("wrapA_target", bus.redirectPc, 32'h0000_0000);
        check("wrapA_busy", 32'(bus.busy), 32'd1);
        check("wrapA_ds_stall", 32'(bus.stall), 32'd0);
        bus.dsAck = 1'b1;
        tick();
        bus.dsAck = 1'b0;
        check("wrapA_redirect", 32'(bus.redirect), 32'd1);
        tick();
        check("wrapA_brCount", 32'(bus.brCount), 32'd5);
        check("wrapA_takenCount", 32'(bus.takenCount), 32'd2);

        // invalid op: no enable, treated as not taken despite takeBranch
        e0 = n_en;
        do_branch(3'b110, 1'b0, 32'h0000_2000, 32'd0, 0, 1'b1);
        check("invalid_no_en", 32'(n_en - e0), 32'd0);
        check("invalid_busy", 32'(bus.busy), 32'd0);
        check("invalid_target", bus.redirectPc, 32'h0000_2004);
        check("invalid_brCount", 32'(bus.brCount), 32'd6);
        check("invalid_takenCount", 32'(bus.takenCount), 32'd2);

        // target wrap downward: bltz taken from 0x4 with offset -2
        do_branch(3'b101, 1'b0, 32'h0000_0004, 32'hFFFF_FFFE, 0, 1'b1);
        check("wrapB_target", bus.redirectPc, 32'h0000_0000);
        bus.dsAck = 1'b1;
        tick();
        bus.dsAck = 1'b0;
        check("wrapB_redirect", 32'(bus.redirect), 32'd1);
        tick();
        check("wrapB_brCount", 32'(bus.brCount), 32'd7);
        check("wrapB_takenCount", 32'(bus.takenCount), 32'd3);

        // flush in WAIT
        e0 = n_en;
        bus.idValid = 1'b1;
        bus.idBraOp = 3'b000;
        bus.idLink  = 1'b0;
        bus.idPc    = 32'h0000_3000;
        tick();
        bus.idValid  = 1'b0;
        bus.opsReady = 1'b1;
        bus.flush    = 1'b1;
        #1;
        check("flushW_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.flush    = 1'b0;
        bus.opsReady = 1'b0;
        check("flushW_busy", 32'(bus.busy), 32'd0);
        check("flushW_en", 32'(bus.braEnable), 32'd0);
        tick();
        check("flushW_no_en", 32'(n_en - e0), 32'd0);
        check("flushW_brCount", 32'(bus.brCount), 32'd7);
        check("flushW_takenCount", 32'(bus.takenCount), 32'd3);

        // flush in DSLOT together with dsAck: no redirect
        r0 = n_red;
        do_branch(3'b000, 1'b0, 32'h0000_4000, 32'd0, 0, 1'b1);
        bus.flush = 1'b1;
        bus.dsAck = 1'b1;
        #1;
        check("flushD_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.flush = 1'b0;
        bus.dsAck = 1'b0;
        check("flushD_redirect", 32'(bus.redirect), 32'd0);
        check("flushD_busy", 32'(bus.busy), 32'd0);
        tick();
        check("flushD_no_redirect", 32'(n_red - r0), 32'd0);
        check("flushD_brCount", 32'(bus.brCount), 32'd8);
        check("flushD_takenCount", 32'(bus.takenCount), 32'd4);

        // flush in EVAL: no count, no link write
        bus.idValid = 1'b1;
        bus.idBraOp = 3'b010;
        bus.idLink  = 1'b1;
        bus.idPc    = 32'h0000_5000;
        tick();
        bus.idValid  = 1'b0;
        bus.opsReady = 1'b1;
        tick();
        bus.opsReady   = 1'b0;
        bus.takeBranch = 1'b1;
        bus.flush      = 1'b1;
        tick();
        bus.takeBranch = 1'b0;
        bus.flush      = 1'b0;
        check("flushE_linkWe", 32'(bus.linkWe), 32'd0);
        check("flushE_busy", 32'(bus.busy), 32'd0);
        check("flushE_brCount", 32'(bus.brCount), 32'd8);
        check("flushE_takenCount", 32'(bus.takenCount), 32'd4);

        // reset asserted in DSLOT
        do_branch(3'b001, 1'b1, 32'h0000_6000, 32'd2, 0, 1'b1);
        check("rstD_linkWe_pre", 32'(bus.linkWe), 32'd1);
        check("rstD_brCount_pre", 32'(bus.brCount), 32'd9);
        check("rstD_takenCount_pre", 32'(bus.takenCount), 32'd5);
        rst_n = 1'b0;
        #1;
        check_all_zero("rstD");
        #1;
        rst_n = 1'b1;
        tick();
        check("rstD_busy_after", 32'(bus.busy), 32'd0);
        check("rstD_redirect_after", 32'(bus.redirect), 32'd0);

        // counter wrap: 16 not-taken branches on a 4-bit counter
        for (int i = 0; i < 16; i++) begin
            do_branch(3'b001, 1'b0, 32'h0000_7000, 32'd0, 0, 1'b0);
        end
        check("wrap_brCount", 32'(bus.brCount), 32'd0);
        check("wrap_takenCount", 32'(bus.takenCount), 32'd0);
        do_branch(3'b000, 1'b0, 32'h0000_7000, 32'd0, 0, 1'b1);
        check("wrap_brCount_next", 32'(bus.brCount), 32'd1);
        check("wrap_takenCount_next", 32'(bus.takenCount), 32'd1);
        bus.dsAck = 1'b1;
        tick();
        bus.dsAck = 1'b0;
        check("wrap_redirect", 32'(bus.redirect), 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
